// File: rtl/dwt_pkg.sv
// Shared constants for the cascaded Haar lifting DWT.
// Band codes, default sizing and the band-field width helper.
package dwt_pkg;

  localparam int W_IN_DEF   = 9;
  localparam int LEVELS_DEF = 3;
  localparam int BAND_A     = 0;

  function automatic int band_w(input int levels);
    return (levels < 1) ? 1 : $clog2(levels + 1);
  endfunction

endpackage

// File: rtl/dwt_lift_stage.sv
// One integer Haar lifting level: holds an even sample,
// emits registered (s, d) when its odd partner arrives.
module dwt_lift_stage
  import dwt_pkg::*;
#(
  parameter int W = W_IN_DEF + LEVELS_DEF + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  output logic [W-1:0] out_s,
  output logic [W-1:0] out_d,
  output logic         out_last
);

  logic                has_e;
  logic signed [W-1:0] e_q;
  logic signed [W-1:0] e_op;
  logic signed [W-1:0] d_c;
  logic signed [W-1:0] s_c;
  logic                pair;

  // partner is the held even, or the sample itself on an even-slot last
  always_comb begin
    e_op = has_e ? e_q : $signed(in_data);
    d_c  = $signed(in_data) - e_op;
    s_c  = e_op + (d_c >>> 1);
  end

  assign pair = in_valid && (has_e || in_last);

  // hold even sample, register the lifted pair on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      has_e     <= 1'b0;
      e_q       <= '0;
      out_valid <= 1'b0;
      out_s     <= '0;
      out_d     <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= pair;
      if (pair) begin
        out_s    <= s_c;
        out_d    <= d_c;
        out_last <= in_last;
        has_e    <= 1'b0;
      end else if (in_valid) begin
        e_q   <= $signed(in_data);
        has_e <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dwt_lift_cascade.sv
// Cascaded Haar lifting DWT with per-band FIFOs
// and a fixed-priority output arbiter.
module dwt_lift_cascade
  import dwt_pkg::*;
#(
  parameter int W_IN       = W_IN_DEF,
  parameter int LEVELS     = LEVELS_DEF,
  parameter int W_OUT      = W_IN + LEVELS + 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W_IN-1:0]           in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W_OUT-1:0]          out_data,
  output logic [band_w(LEVELS)-1:0] out_band,
  output logic                      out_last
);

  localparam int BW = band_w(LEVELS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int NB = LEVELS + 1;

  logic             run;
  logic             room;
  logic [LEVELS:0]  s_vld;
  logic [LEVELS:0]  s_lst;
  logic [W_OUT-1:0] s_dat [NB];
  logic [W_OUT-1:0] d_dat [1:LEVELS];

  logic [NB-1:0]    wr_en;
  logic [W_OUT:0]   wr_ent [NB];
  logic [CW-1:0]    cnt [NB];
  logic [W_OUT:0]   head [NB];
  logic [NB-1:0]    pop;

  logic [BW-1:0]    sel;
  logic             any;
  logic             load;

  assign s_vld[0] = in_valid && in_ready;
  assign s_lst[0] = in_last;
  assign s_dat[0] = {{(W_OUT - W_IN){in_data[W_IN-1]}}, in_data};

  for (genvar l = 1; l <= LEVELS; l++) begin : g_stage
    dwt_lift_stage #(.W(W_OUT)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_vld[l-1]),
      .in_data   (s_dat[l-1]),
      .in_last   (s_lst[l-1]),
      .out_valid (s_vld[l]),
      .out_s     (s_dat[l]),
      .out_d     (d_dat[l]),
      .out_last  (s_lst[l])
    );
  end

  assign wr_en[0]  = s_vld[LEVELS];
  assign wr_ent[0] = {s_lst[LEVELS], s_dat[LEVELS]};

  for (genvar l = 1; l <= LEVELS; l++) begin : g_wr
    assign wr_en[l]  = s_vld[l];
    assign wr_ent[l] = {1'b0, d_dat[l]};
  end

  for (genvar b = 0; b < NB; b++) begin : g_fifo
    logic [W_OUT:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic [CW-1:0]   n;

    // entry storage; reads are gated by the fill level
    always_ff @(posedge clk) begin
      if (wr_en[b]) mem[wp] <= wr_ent[b];
    end

    // pointers and fill level, write+pop nets to no change
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wp <= '0;
        rp <= '0;
        n  <= '0;
      end else begin
        if (wr_en[b])
          wp <= (wp == PW'(FIFO_DEPTH - 1)) ? '0 : wp + 1'b1;
        if (pop[b])
          rp <= (rp == PW'(FIFO_DEPTH - 1)) ? '0 : rp + 1'b1;
        n <= n + CW'(wr_en[b]) - CW'(pop[b]);
      end
    end

    assign cnt[b]  = n;
    assign head[b] = mem[rp];
  end

  // admit a sample only if every band has room for all
  // results still moving through the stages plus this one
  always_comb begin
    int pend;
    room = 1'b1;
    pend = 1;
    for (int l = 1; l <= LEVELS; l++) begin
      pend += int'(s_vld[l]);
      if (int'(cnt[l]) > FIFO_DEPTH - 2 ||
          int'(cnt[l]) + pend > FIFO_DEPTH)
        room = 1'b0;
    end
    if (int'(cnt[0]) > FIFO_DEPTH - 2 ||
        int'(cnt[0]) + pend > FIFO_DEPTH)
      room = 1'b0;
  end

  assign in_ready = run && room;

  // enable input one edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run <= 1'b0;
    else     run <= 1'b1;
  end

  // fixed priority: D1 first, approximation only when details drained
  always_comb begin
    sel = BW'(BAND_A);
    any = (cnt[0] != '0);
    for (int l = LEVELS; l >= 1; l--) begin
      if (cnt[l] != '0) begin
        sel = BW'(l);
        any = 1'b1;
      end
    end
  end

  assign load = any && (!out_valid || out_ready);

  // one-hot pop of the selected band
  always_comb begin
    for (int b = 0; b < NB; b++)
      pop[b] = load && (sel == BW'(b));
  end

  // output register holds its entry until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_band  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= head[sel][W_OUT-1:0];
      out_band  <= sel;
      out_last  <= head[sel][W_OUT];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dwt_lift_cascade.sv
// Bench for dwt_lift_cascade: directed frames, random frames,
// backpressure and mid-frame reset against a frame-level model.
module tb_dwt_lift_cascade;

  localparam int W_IN  = 9;
  localparam int LV    = 3;
  localparam int W_OUT = W_IN + LV + 1;
  localparam int BW    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W_IN-1:0]  in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W_OUT-1:0] out_data;
  logic [BW-1:0]    out_band;
  logic             out_last;

  int n_chk = 0;
  int n_fail = 0;
  int exq [LV+1][$];
  bit exl [$];
  int log_b [$];
  int log_v [$];
  int rdy_mode = 0;

  dwt_lift_cascade #(
    .W_IN       (W_IN),
    .LEVELS     (LV),
    .W_OUT      (W_OUT),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_band  (out_band),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int floor_half(input int d);
    return (d >= 0) ? d / 2 : -((1 - d) / 2);
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int b = 0; b <= LV; b++) s += exq[b].size();
    return s;
  endfunction

  // whole-frame Haar decomposition, pushed as expected per band
  task automatic model_frame(input int xs[$]);
    int cur[$];
    int nxt[$];
    int e, o, d;
    cur = xs;
    for (int l = 1; l <= LV; l++) begin
      nxt.delete();
      for (int i = 0; i < cur.size(); i += 2) begin
        e = cur[i];
        o = (i + 1 < cur.size()) ? cur[i+1] : cur[i];
        d = o - e;
        exq[l].push_back(d);
        nxt.push_back(e + floor_half(d));
      end
      cur = nxt;
    end
    for (int i = 0; i < cur.size(); i++) begin
      exq[0].push_back(cur[i]);
      exl.push_back(i == cur.size() - 1);
    end
  endtask

  task automatic send(input int v, input bit last);
    bit done = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_data  = W_IN'(v);
    in_last  = last;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 2000) begin
        chk("send_timeout", n, 0);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int xs[$]);
    for (int i = 0; i < xs.size(); i++)
      send(xs[i], i == xs.size() - 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((pending() != 0 || out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, pending(), 0);
  endtask

  // downstream ready pattern
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // scoreboard on accepted coefficients
  always @(negedge clk) begin
    int b, v, e;
    if (!rst && out_valid && out_ready) begin
      b = int'(out_band);
      v = int'($signed(out_data));
      log_b.push_back(b);
      log_v.push_back(v);
      chk($sformatf("expected_b%0d", b),
          (exq[b].size() > 0) ? 1 : 0, 1);
      if (exq[b].size() > 0) begin
        e = exq[b].pop_front();
        chk($sformatf("data_b%0d", b), v, e);
        if (b == 0)
          chk("last_a", int'(out_last), int'(exl.pop_front()));
        else
          chk($sformatf("last_b%0d", b), int'(out_last), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs[$];
    int eb[5];
    int ev[5];
    int x;
    int len;
    bit ok;
    bit first_rdy;
    eb = '{1, 1, 2, 3, 0};
    ev = '{-6, 2, 0, 0, 7};
    first_rdy = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_band", int'(out_band), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_before_edge", int'(in_ready), 0);
    @(negedge clk);
    chk("rdy_after_edge", int'(in_ready), 1);
    @(posedge clk);
    #1;

    log_b.delete();
    log_v.delete();
    xs = '{10, 4, 6, 8};
    model_frame(xs);
    send_frame(xs);
    drain("drain_dir1");
    chk("dir1_len", log_b.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < log_b.size()) begin
        chk($sformatf("dir1_band%0d", i), log_b[i], eb[i]);
        chk($sformatf("dir1_val%0d", i), log_v[i], ev[i]);
      end
    end

    xs = '{5};
    model_frame(xs);
    send_frame(xs);
    drain("drain_single");

    xs.delete();
    for (int i = 0; i < 8; i++) xs.push_back(100);
    model_frame(xs);
    send_frame(xs);
    drain("drain_const");

    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      len = int'($urandom_range(1, 14));
      xs.delete();
      for (int i = 0; i < len; i++) xs.push_back(rand_sample());
      model_frame(xs);
      send_frame(xs);
    end
    rdy_mode = 0;
    drain("drain_random");

    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    xs.delete();
    x = rand_sample();
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_data  = W_IN'(x);
      in_last  = 1'b0;
      @(negedge clk);
      ok = in_ready;
      if (c == 0) first_rdy = ok;
      @(posedge clk);
      #1;
      if (ok) begin
        xs.push_back(x);
        x = rand_sample();
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_in_ready_low", int'(in_ready), 0);
    chk("stall_first_ready", int'(first_rdy), 1);
    chk("stall_acc_bound",
        (xs.size() >= 4 && xs.size() <= 11) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    xs.push_back(x);
    model_frame(xs);
    rdy_mode = 0;
    send(x, 1'b1);
    drain("drain_stall");

    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(3, 1'b0);
    send(-7, 1'b0);
    send(20, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    log_b.delete();
    log_v.delete();
    xs = '{10, 4};
    model_frame(xs);
    send_frame(xs);
    drain("drain_midrst");
    chk("midrst_len", log_b.size(), 4);
    if (log_b.size() > 0) begin
      chk("midrst_first_band", log_b[0], 1);
      chk("midrst_first_val", log_v[0], -6);
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dwt_lift_cascade.md
DWT_LIFT_CASCADE -- requirements
Module: dwt_lift_cascade

Interface
REQ-001 SHALL have parameter W_IN, default 9: input sample width, signed two's complement.
REQ-002 SHALL have parameter LEVELS, default 3, legal range 1..4: number of cascaded decomposition levels.
REQ-003 SHALL have parameter W_OUT, default W_IN+LEVELS+1: coefficient width, all arithmetic in W_OUT.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, minimum 4: entries per band FIFO.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge; no derived clocks.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: input sample present.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a sample.
REQ-009 SHALL have port in_data, input, W_IN bits: signed sample.
REQ-010 SHALL have port in_last, input, 1 bit: final sample of the frame.
REQ-011 SHALL have port out_valid, output, 1 bit: coefficient present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-013 SHALL have port out_data, output, W_OUT bits: signed coefficient.
REQ-014 SHALL have port out_band, output, clog2(LEVELS+1) bits: 0 = approximation A_LEVELS; l = detail D_l.
REQ-015 SHALL have port out_last, output, 1 bit: final coefficient of the frame.

Function
REQ-016 SHALL transfer on valid&&ready only; once asserted, out_valid/out_data/out_band/out_last SHALL hold until accepted.
REQ-017 SHALL implement per level integer Haar lifting on pair (e = even sample, o = odd sample): d = o - e; s = e + (d >>> 1), arithmetic shift, floor.
REQ-018 SHALL sign-extend inputs to W_OUT; no saturation; W_OUT sized so overflow cannot occur.
REQ-019 Each stage SHALL hold one even sample; on the odd sample it SHALL register d and s (1-cycle latency per stage).
REQ-020 Stage l's d SHALL be written to FIFO D_l; its s SHALL feed stage l+1 as a valid sample, or FIFO A when l = LEVELS.
REQ-021 Frame end: last on an odd slot SHALL pair normally; last on an even slot SHALL self-pair (o = e, so d = 0, s = e).
REQ-022 In both frame-end cases the stage SHALL forward last with s and clear its held-even flag.
REQ-023 The A entry carrying last SHALL set out_last; no other entry sets it.
REQ-024 Output arbiter SHALL use fixed priority D_1 > D_2 > ... > D_LEVELS > A; A SHALL pop only when all detail FIFOs are empty.
REQ-025 in_ready SHALL be 1 only when every FIFO count <= FIFO_DEPTH-2; this guarantees no FIFO overflow with in-flight stage results.
REQ-026 A FIFO write and pop in the same cycle SHALL leave count unchanged.
REQ-027 Accepted throughput SHALL be 1 sample/cycle sustained while out_ready = 1.
REQ-028 A new frame SHALL start the cycle after in_last is accepted, with no idle gap required.

Reset
REQ-029 While rst = 1: all FIFOs empty, held-even flags cleared, out_valid = 0, out_data = 0, out_band = 0, out_last = 0, in_ready = 0.
REQ-030 in_ready SHALL go to 1 on the first clock edge after rst deasserts.
REQ-031 rst asserted mid-frame SHALL discard all partial pairs and queued coefficients; the next sample starts a new frame at an even slot.

Structure
REQ-032 Shared package dwt_pkg SHALL hold the band-code constants (BAND_A = 0), the default W_IN/LEVELS, and a clog2-based band-width function.
REQ-033 One lifting level SHALL be sub-module dwt_lift_stage, instantiated LEVELS times by generate.
REQ-034 FIFOs and the arbiter SHALL be in the top level.

Verification
REQ-035 LEVELS=2, out_ready=1, input 10,4,6,8 (last on 8) -> sequence (1,-6),(1,2),(2,0),(0,7); out_last only on (0,7).
REQ-036 LEVELS=1, single sample 5 with last -> (1,0) then (0,5) with out_last=1.
REQ-037 LEVELS=3, eight samples of 100 -> seven detail outputs all 0, then (0,100) with out_last.
REQ-038 LEVELS=3, continuous input, out_ready low 20 cycles -> in_ready drops within 1 cycle; no FIFO overflow.
REQ-039 Continuation of REQ-038 -> after out_ready returns, coefficients match the golden model bit-exact with no loss.
REQ-040 rst pulsed after 3 samples of a frame, then 10,4 with last, LEVELS=1 -> outputs only (1,-6),(0,7); out_last on (0,7).
